// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory bus port between instruction fetch (IF) and the
//   memory stage (D). Only one transaction is outstanding at a time.
//   Priority alternates between the two requesters. A fetch killed by a
//   branch redirect (if_flush) still completes on the bus, but its
//   response is dropped.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to enable a watchdog.
//   After TIMEOUT cycles in REQ/WAIT the arbiter returns to IDLE,
//   delivers a zero response to the owner and sets sticky timeout_err.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req_* / if_flush      fetch request, redirect kill
//   if_resp_*                fetch response pulse, instruction word
//   d_req_*                  data load/store request
//   d_resp_*                 data response pulse (also pulses for stores)
//   bus_req_* / bus_resp_*   unified memory bus
//   if_busy, d_busy          stall requests to the pipeline control
//   timeout_err              sticky watchdog error (0 without the feature)
//
// state | meaning
// IDLE  | no transaction; grant decided combinationally
// REQ   | bus_req_valid held with latched fields until bus_req_ready
// WAIT  | request accepted by bus, waiting for bus_resp_valid
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    input  logic                if_flush,
    output logic                if_resp_valid,
    output logic [31:0]         if_resp_instr,
    input  logic                d_req_valid,
    input  logic                d_req_wen,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wmask,
    output logic                d_req_ready,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_data,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic                bus_req_wen,
    output logic [DATA_W-1:0]   bus_req_wdata,
    output logic [DATA_W/8-1:0] bus_req_wmask,
    input  logic                bus_resp_valid,
    input  logic [DATA_W-1:0]   bus_resp_data,
    output logic                if_busy,
    output logic                d_busy,
    output logic                timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} arbState;

    arbState             state, nextState;
    logic                ownerIsD, lastOwnerIsD, drop;
    logic [ADDR_W-1:0]   addrQ;
    logic                wenQ;
    logic [DATA_W-1:0]   wdataQ;
    logic [DATA_W/8-1:0] wmaskQ;

    logic arbIdle, ifCand, grantD, grantIf;
    logic respDone, toHit, finish, flushHit, dropNow;
    logic [DATA_W-1:0] respData;

    // Grants are also gated by reset so every output reads 0 while held.
    assign arbIdle  = (state == IDLE) & rst;
    assign ifCand   = if_req_valid & ~if_flush;
    assign grantD   = arbIdle & d_req_valid & ~(ifCand & lastOwnerIsD);
    assign grantIf  = arbIdle & ifCand & ~grantD;
    assign d_req_ready  = grantD;
    assign if_req_ready = grantIf;

    assign flushHit = if_flush & ~ownerIsD & (state != IDLE);
    // A flush in the completion cycle itself must still kill the response.
    assign dropNow  = drop | flushHit;
    assign finish   = respDone | toHit;
    assign respData = toHit ? '0 : bus_resp_data;

    always_comb begin
        nextState = state;
        respDone  = 1'b0;
        case (state)
            IDLE: if (grantD | grantIf) nextState = REQ;
            REQ:  if (bus_req_ready)    nextState = WAIT;
            WAIT: if (bus_resp_valid) begin
                nextState = IDLE;
                respDone  = 1'b1;
            end
            default: nextState = IDLE;
        endcase
`ifdef MEM_ARB_TIMEOUT_EN
        if (toHit) nextState = IDLE;
`endif
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt;
    logic             errQ;

    assign toHit       = (state != IDLE) & ~respDone & (cnt == CNT_W'(TIMEOUT));
    assign timeout_err = errQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            errQ <= 1'b0;
        end else begin
            if (state == IDLE)   cnt <= '0;
            else                 cnt <= cnt + 1'b1;
            if (toHit)           errQ <= 1'b1;
        end
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT;
    assign toHit         = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ownerIsD      <= 1'b0;
            lastOwnerIsD  <= 1'b0;
            drop          <= 1'b0;
            addrQ         <= '0;
            wenQ          <= 1'b0;
            wdataQ        <= '0;
            wmaskQ        <= '0;
            if_resp_valid <= 1'b0;
            if_resp_instr <= '0;
            d_resp_valid  <= 1'b0;
            d_resp_data   <= '0;
        end else begin
            state <= nextState;
            if (grantD) begin
                ownerIsD <= 1'b1;
                addrQ    <= d_req_addr;
                wenQ     <= d_req_wen;
                wdataQ   <= d_req_wdata;
                wmaskQ   <= d_req_wmask;
            end else if (grantIf) begin
                ownerIsD <= 1'b0;
                addrQ    <= if_req_addr;
                wenQ     <= 1'b0;
                wdataQ   <= '0;
                wmaskQ   <= '0;
            end
            if (finish) begin
                lastOwnerIsD <= ownerIsD;
                drop         <= 1'b0;
            end else if (flushHit) begin
                drop <= 1'b1;
            end
            // Response registers are zero outside their one-cycle pulse.
            if_resp_valid <= finish & ~ownerIsD & ~dropNow;
            if_resp_instr <= (finish & ~ownerIsD & ~dropNow)
                             ? (addrQ[2] ? respData[63:32] : respData[31:0]) : '0;
            d_resp_valid  <= finish & ownerIsD;
            d_resp_data   <= (finish & ownerIsD) ? respData : '0;
        end
    end

    assign bus_req_valid = (state == REQ);
    assign bus_req_addr  = (state == REQ) ? addrQ  : '0;
    assign bus_req_wen   = (state == REQ) & wenQ;
    assign bus_req_wdata = (state == REQ) ? wdataQ : '0;
    assign bus_req_wmask = (state == REQ) ? wmaskQ : '0;

    assign d_busy  = rst & ((d_req_valid & ~d_req_ready) | (ownerIsD & (state != IDLE)));
    assign if_busy = rst & ((if_req_valid & ~if_req_ready & ~if_flush)
                          | (~ownerIsD & (state != IDLE) & ~drop));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: reset state, alternating
//   contention, fetch word select, load latency, store with bus
//   backpressure, flush dropping, async reset abandonment and, when
//   MEM_ARB_TIMEOUT_EN is defined, the watchdog (TIMEOUT = 8).
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        if_req_valid, if_req_ready, if_flush, if_resp_valid;
    logic [63:0] if_req_addr;
    logic [31:0] if_resp_instr;
    logic        d_req_valid, d_req_wen, d_req_ready, d_resp_valid;
    logic [63:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [7:0]  d_req_wmask;
    logic        bus_req_valid, bus_req_ready, bus_req_wen, bus_resp_valid;
    logic [63:0] bus_req_addr, bus_req_wdata, bus_resp_data;
    logic [7:0]  bus_req_wmask;
    logic        if_busy, d_busy, timeout_err;

    int nChecks = 0;
    int nFails  = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_instr(if_resp_instr),
        .d_req_valid(d_req_valid), .d_req_wen(d_req_wen), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr), .bus_req_wen(bus_req_wen),
        .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
        .if_busy(if_busy), .d_busy(d_busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction from a single requester; bus accepts after
    // 'stall' REQ cycles, one idle WAIT cycle, then the response.
    task automatic runXact(input bit isD, input bit wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wmask,
                           input logic [63:0] rdata, input int stall,
                           input logic [63:0] expResp);
        @(negedge clk);
        if (isD) begin
            d_req_valid = 1'b1; d_req_wen = wen; d_req_addr = addr;
            d_req_wdata = wdata; d_req_wmask = wmask;
        end else begin
            if_req_valid = 1'b1; if_req_addr = addr;
        end
        bus_req_ready = 1'b0;
        #1 checkVal("accept", isD ? d_req_ready : if_req_ready, 64'd1);
        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            d_req_valid = 1'b0; if_req_valid = 1'b0;
            d_req_wdata = '0; d_req_wmask = '0; d_req_addr = '0;
            bus_req_ready = (k == stall);
            #1;
            checkVal("reqValid", bus_req_valid, 64'd1);
            checkVal("reqAddr", bus_req_addr, addr);
            checkVal("reqWen", bus_req_wen, isD ? wen : 1'b0);
            checkVal("reqWdata", bus_req_wdata, isD ? wdata : 64'd0);
            checkVal("reqWmask", bus_req_wmask, isD ? wmask : 8'd0);
            checkVal("busyReq", isD ? d_busy : if_busy, 64'd1);
        end
        @(negedge clk);
        bus_req_ready = 1'b0;
        #1 checkVal("reqDropped", bus_req_valid, 64'd0);
        checkVal("busyWait", isD ? d_busy : if_busy, 64'd1);
        @(negedge clk);
        bus_resp_valid = 1'b1; bus_resp_data = rdata;
        #1 checkVal("busyResp", isD ? d_busy : if_busy, 64'd1);
        checkVal("noEarlyResp", isD ? d_resp_valid : if_resp_valid, 64'd0);
        @(negedge clk);
        bus_resp_valid = 1'b0; bus_resp_data = '0;
        #1 checkVal("respValid", isD ? d_resp_valid : if_resp_valid, 64'd1);
        checkVal("otherResp", isD ? if_resp_valid : d_resp_valid, 64'd0);
        checkVal("respData", isD ? d_resp_data : {32'd0, if_resp_instr}, expResp);
        checkVal("busyDone", isD ? d_busy : if_busy, 64'd0);
        @(negedge clk);
        #1 checkVal("respPulse", isD ? d_resp_valid : if_resp_valid, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        if_req_valid = 0; if_req_addr = '0; if_flush = 0;
        d_req_valid = 0; d_req_wen = 0; d_req_addr = '0; d_req_wdata = '0; d_req_wmask = '0;
        bus_req_ready = 0; bus_resp_valid = 0; bus_resp_data = '0;
        #1;
        checkVal("rstBusValid", bus_req_valid, 0);
        checkVal("rstIfBusy", if_busy, 0);
        checkVal("rstDBusy", d_busy, 0);
        checkVal("rstDResp", d_resp_valid, 0);
        checkVal("rstIfResp", if_resp_valid, 0);
        checkVal("rstTimeout", timeout_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Contention from reset: D, then IF, then D.
        bus_req_ready = 1'b1;
        @(negedge clk);
        if_req_valid = 1; if_req_addr = 64'h8000_0000;
        d_req_valid = 1; d_req_addr = 64'h100;
        #1 checkVal("c1DReady", d_req_ready, 1);
        checkVal("c1IfReady", if_req_ready, 0);
        checkVal("c1IfBusy", if_busy, 1);
        @(negedge clk);
        d_req_valid = 0;
        #1 checkVal("c1BusAddr", bus_req_addr, 64'h100);
        checkVal("c1IfBusyReq", if_busy, 1);
        @(negedge clk);
        bus_resp_valid = 1; bus_resp_data = 64'h5555;
        #1 checkVal("c1IfBusyWait", if_busy, 1);
        @(negedge clk);
        bus_resp_valid = 0; d_req_valid = 1; d_req_addr = 64'h108;
        #1 checkVal("c1DResp", d_resp_valid, 1);
        checkVal("c1DData", d_resp_data, 64'h5555);
        checkVal("c2IfReady", if_req_ready, 1);
        checkVal("c2DReady", d_req_ready, 0);
        checkVal("c2DBusy", d_busy, 1);
        @(negedge clk);
        if_req_valid = 0;
        #1 checkVal("c2BusAddr", bus_req_addr, 64'h8000_0000);
        checkVal("c2DBusyReq", d_busy, 1);
        @(negedge clk);
        bus_resp_valid = 1; bus_resp_data = 64'hAAAA_AAAA_BBBB_BBBB;
        #1 checkVal("c2DBusyWait", d_busy, 1);
        @(negedge clk);
        bus_resp_valid = 0;
        #1 checkVal("c2IfResp", if_resp_valid, 1);
        checkVal("c2Instr", {32'd0, if_resp_instr}, 64'hBBBB_BBBB);
        checkVal("c3DReady", d_req_ready, 1);
        @(negedge clk);
        d_req_valid = 0;
        #1 checkVal("c3BusAddr", bus_req_addr, 64'h108);
        @(negedge clk);
        bus_resp_valid = 1; bus_resp_data = 64'h77;
        @(negedge clk);
        bus_resp_valid = 0;
        #1 checkVal("c3DResp", d_resp_valid, 1);
        checkVal("c3DData", d_resp_data, 64'h77);

        // Word select, single load latency, store with backpressure.
        runXact(0, 0, 64'h8000_0004, 0, 0, 64'hAAAA_AAAA_BBBB_BBBB, 0, 64'hAAAA_AAAA);
        runXact(1, 0, 64'h8000_0010, 0, 0, 64'h1122_3344_5566_7788, 0, 64'h1122_3344_5566_7788);
        runXact(1, 1, 64'h8000_0020, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 64'h0, 5, 64'h0);
        runXact(0, 0, 64'h8000_0000, 0, 0, 64'hAAAA_AAAA_BBBB_BBBB, 0, 64'hBBBB_BBBB);

        // Flush in IDLE masks the fetch request.
        @(negedge clk);
        if_req_valid = 1; if_req_addr = 64'h8000_0040; if_flush = 1;
        #1 checkVal("flushIdleReady", if_req_ready, 0);
        checkVal("flushIdleBusy", if_busy, 0);
        @(negedge clk);
        if_req_valid = 0; if_flush = 0;

        // Flush in WAIT drops the response.
        @(negedge clk);
        if_req_valid = 1; if_req_addr = 64'h8000_0008; bus_req_ready = 1;
        #1 checkVal("fAccept", if_req_ready, 1);
        @(negedge clk);
        if_req_valid = 0;
        #1 checkVal("fReqValid", bus_req_valid, 1);
        @(negedge clk);
        bus_req_ready = 0; if_flush = 1;
        #1 checkVal("fBusyAtFlush", if_busy, 1);
        @(negedge clk);
        if_flush = 0; bus_resp_valid = 1; bus_resp_data = 64'h1234_5678_9ABC_DEF0;
        #1 checkVal("fBusyAfter", if_busy, 0);
        @(negedge clk);
        bus_resp_valid = 0;
        #1 checkVal("fNoResp", if_resp_valid, 0);
        checkVal("fInstrZero", {32'd0, if_resp_instr}, 0);
        runXact(0, 0, 64'h8000_0008, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 64'h89AB_CDEF);

        // Async reset in WAIT abandons the transaction.
        @(negedge clk);
        d_req_valid = 1; d_req_wen = 0; d_req_addr = 64'h200; bus_req_ready = 1;
        #1 checkVal("rAccept", d_req_ready, 1);
        @(negedge clk);
        d_req_valid = 0;
        @(negedge clk);
        bus_req_ready = 0;
        #1 checkVal("rBusyWait", d_busy, 1);
        #2 rst = 0;
        #1 checkVal("rDBusy", d_busy, 0);
        checkVal("rBusValid", bus_req_valid, 0);
        checkVal("rBusAddr", bus_req_addr, 0);
        checkVal("rDResp", d_resp_valid, 0);
        @(negedge clk);
        rst = 1; bus_resp_valid = 1; bus_resp_data = 64'h99;
        @(negedge clk);
        bus_resp_valid = 0;
        #1 checkVal("rLateResp", d_resp_valid, 0);
        checkVal("rLateBusy", d_busy, 0);
        checkVal("rTimeoutErr", timeout_err, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Bus accepts but never responds; watchdog fires after 8 cycles.
        @(negedge clk);
        d_req_valid = 1; d_req_addr = 64'h300; bus_req_ready = 1;
        #1 checkVal("tAccept", d_req_ready, 1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) d_req_valid = 0;
            if (c == 2) bus_req_ready = 0;
            #1;
            checkVal($sformatf("tResp%0d", c), d_resp_valid, (c == 10) ? 64'd1 : 64'd0);
            checkVal($sformatf("tErr%0d", c), timeout_err, (c >= 10) ? 64'd1 : 64'd0);
            checkVal($sformatf("tData%0d", c), d_resp_data, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
